// File: rtl/flt_sched_pkg.sv
// flt_sched_pkg
// Shared constants for the float_unit scheduler: field widths, the float_unit
// opcode map and the opcode legality check.
package flt_sched_pkg;

    localparam int OPER_W = 4;
    localparam int DATA_W = 32;
    localparam int DST_W  = 3;

    localparam logic [OPER_W-1:0] OP_ADD = 4'd1;
    localparam logic [OPER_W-1:0] OP_SUB = 4'd2;
    localparam logic [OPER_W-1:0] OP_MUL = 4'd3;
    localparam logic [OPER_W-1:0] OP_FAB = 4'd4;
    localparam logic [OPER_W-1:0] OP_MAX = 4'd5;
    localparam logic [OPER_W-1:0] OP_MIN = 4'd6;
    localparam logic [OPER_W-1:0] OP_NEG = 4'd7;
    localparam logic [OPER_W-1:0] OP_DIV = 4'd8;
    localparam logic [OPER_W-1:0] OP_SQR = 4'd9;
    localparam logic [OPER_W-1:0] OP_SIN = 4'd10;
    localparam logic [OPER_W-1:0] OP_COS = 4'd11;

    function automatic logic is_legal_op(input logic [OPER_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_FAB, OP_MAX, OP_MIN,
            OP_NEG, OP_DIV, OP_SQR, OP_SIN, OP_COS: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/flt_sched_if.sv
// flt_sched_if
// Bundles the requester request/ack bus, the float_unit issue/result bus and
// the response bus of the scheduler.
//   slave  : scheduler view (requests and float_unit results in; ack, issue and
//            responses out)
//   master : requester / float_unit / environment view
// Parameters: NREQ requesters, IDW requester id width.
interface flt_sched_if
    import flt_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
);
    logic [NREQ-1:0]        req_vld;
    logic [NREQ*OPER_W-1:0] req_oper;
    logic [NREQ*DATA_W-1:0] req_src0;
    logic [NREQ*DATA_W-1:0] req_src1;
    logic [NREQ*DST_W-1:0]  req_dst;
    logic [NREQ-1:0]        req_ack;

    logic                   fu_vldin;
    logic [OPER_W-1:0]      fu_oper;
    logic [DATA_W-1:0]      fu_src0;
    logic [DATA_W-1:0]      fu_src1;
    logic                   fu_vldout;
    logic [DATA_W-1:0]      fu_result;

    logic                   rsp_vld;
    logic [IDW-1:0]         rsp_id;
    logic [DST_W-1:0]       rsp_dst;
    logic [DATA_W-1:0]      rsp_result;

    modport slave (
        input  req_vld, req_oper, req_src0, req_src1, req_dst,
        input  fu_vldout, fu_result,
        output req_ack,
        output fu_vldin, fu_oper, fu_src0, fu_src1,
        output rsp_vld, rsp_id, rsp_dst, rsp_result
    );

    modport master (
        output req_vld, req_oper, req_src0, req_src1, req_dst,
        output fu_vldout, fu_result,
        input  req_ack,
        input  fu_vldin, fu_oper, fu_src0, fu_src1,
        input  rsp_vld, rsp_id, rsp_dst, rsp_result
    );

endinterface

// File: rtl/flt_sched_tagfifo.sv
// flt_sched_tagfifo
// Synchronous FIFO holding the {requester id, dst} tag of every operation in
// flight on float_unit. Depth must be a power of two (>= 2) so the pointers
// wrap naturally; occupancy is kept as an explicit count.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push, din  write a tag (caller guarantees not full)
//   pop, dout  dout shows the oldest tag; pop discards it (caller guarantees
//              not empty)
//   flush      drop every stored tag; wins over push/pop in the same cycle
//   count      number of stored tags, 0..DEPTH
module flt_sched_tagfifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    assign dout = mem[rptr];

endmodule

// File: rtl/flt_scheduler.sv
// flt_scheduler
// Shares one float_unit between NREQ command sources. A round-robin arbiter
// grants one requester per cycle while credits remain, legal operations are
// issued to float_unit one cycle after the grant, and results (returned in
// issue order) are routed back to their owner through a tag FIFO.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   bus           flt_sched_if.slave: requests/ack, float_unit issue/result,
//                 responses
//   err_clr       synchronous clear of the sticky error flags (set wins)
//   outstanding   operations in flight
//   err_badop     sticky: request with illegal opcode dropped
//   err_orphan    sticky: float_unit result with no operation in flight
//   err_timeout   sticky: watchdog flushed the in-flight operations
// Build option: define FLT_SCHED_WATCHDOG_EN to build the watchdog; without
// it err_timeout is tied low and TIMEOUT is ignored.
module flt_scheduler
    import flt_sched_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DEPTH   = 4,
    parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    flt_sched_if.slave             bus,
    input  logic                   err_clr,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   err_badop,
    output logic                   err_orphan,
    output logic                   err_timeout
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = IDW + DST_W;

    logic [IDW-1:0]    last_grant;
    logic [IDW-1:0]    cand;
    logic [IDW-1:0]    gnt_idx;
    logic              gnt_any;
    logic              credit_ok;
    logic [OPER_W-1:0] gnt_oper;
    logic [DATA_W-1:0] gnt_src0;
    logic [DATA_W-1:0] gnt_src1;
    logic [DST_W-1:0]  gnt_dst;
    logic              gnt_legal;
    logic              issue;
    logic              pop;
    logic              orphan;
    logic              flush;
    logic [TW-1:0]     tag_head;

    // Credits come from the registered count, so a pop cannot release a grant
    // in its own cycle.
    assign credit_ok = !rst && (outstanding < CW'(DEPTH));

    // Round-robin: search starts one past the last winner and wraps.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % NREQ);
            if (credit_ok && !gnt_any && bus.req_vld[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign bus.req_ack = gnt_any ? (NREQ'(1) << gnt_idx) : '0;

    assign gnt_oper  = bus.req_oper[gnt_idx*OPER_W +: OPER_W];
    assign gnt_src0  = bus.req_src0[gnt_idx*DATA_W +: DATA_W];
    assign gnt_src1  = bus.req_src1[gnt_idx*DATA_W +: DATA_W];
    assign gnt_dst   = bus.req_dst[gnt_idx*DST_W +: DST_W];
    assign gnt_legal = is_legal_op(gnt_oper);
    assign issue     = gnt_any && gnt_legal;

    assign pop    = bus.fu_vldout && (outstanding != '0);
    assign orphan = bus.fu_vldout && (outstanding == '0);

    flt_sched_tagfifo #(
        .W     (TW),
        .DEPTH (DEPTH)
    ) u_tagfifo (
        .clk   (clk),
        .rst   (rst),
        .push  (issue),
        .din   ({gnt_idx, gnt_dst}),
        .pop   (pop),
        .dout  (tag_head),
        .flush (flush),
        .count (outstanding)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant     <= IDW'(NREQ - 1);
            bus.fu_vldin   <= 1'b0;
            bus.fu_oper    <= '0;
            bus.fu_src0    <= '0;
            bus.fu_src1    <= '0;
            bus.rsp_vld    <= 1'b0;
            bus.rsp_id     <= '0;
            bus.rsp_dst    <= '0;
            bus.rsp_result <= '0;
            err_badop      <= 1'b0;
            err_orphan     <= 1'b0;
        end else begin
            if (gnt_any) last_grant <= gnt_idx;

            bus.fu_vldin <= issue;
            if (issue) begin
                bus.fu_oper <= gnt_oper;
                bus.fu_src0 <= gnt_src0;
                bus.fu_src1 <= gnt_src1;
            end

            bus.rsp_vld <= pop;
            if (pop) begin
                bus.rsp_id     <= tag_head[TW-1 -: IDW];
                bus.rsp_dst    <= tag_head[DST_W-1:0];
                bus.rsp_result <= bus.fu_result;
            end

            err_badop  <= (gnt_any && !gnt_legal) || (err_badop && !err_clr);
            err_orphan <= orphan || (err_orphan && !err_clr);
        end
    end

`ifdef FLT_SCHED_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    logic [15:0] wd_cnt;
    logic        wd_fire;

    // wd_cnt counts earlier consecutive cycles with work in flight and no
    // result; the TIMEOUT-th such cycle fires.
    assign wd_fire = (outstanding != '0) && !bus.fu_vldout && (wd_cnt == WD_LAST);
    assign flush   = wd_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (bus.fu_vldout || wd_fire || (outstanding == '0))
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 16'd1;
            err_timeout <= wd_fire || (err_timeout && !err_clr);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg  = ^32'(TIMEOUT);
    assign flush       = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_flt_scheduler.sv
module tb_flt_scheduler;
    import flt_sched_pkg::*;

    localparam int NREQ    = 2;
    localparam int DEPTH   = 4;
    localparam int IDW     = 1;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_clr = 1'b0;
    logic [$clog2(DEPTH):0] outstanding;
    logic err_badop, err_orphan, err_timeout;

    flt_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    flt_scheduler #(
        .NREQ(NREQ), .DEPTH(DEPTH), .IDW(IDW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .err_clr     (err_clr),
        .outstanding (outstanding),
        .err_badop   (err_badop),
        .err_orphan  (err_orphan),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int id; int dst; } tag_t;
    tag_t q[$];
    int          m_last = NREQ - 1;
    bit          e_fu_vld = 0;
    logic [31:0] e_op = 0, e_s0 = 0, e_s1 = 0;
    bit          e_rsp_vld = 0;
    logic [31:0] e_rsp_id = 0, e_rsp_dst = 0, e_rsp_res = 0;
    bit          e_badop = 0, e_orphan = 0, e_timeout = 0;
    int          idle = 0;

    task automatic model_reset();
        q.delete();
        m_last = NREQ - 1;
        e_fu_vld = 0; e_rsp_vld = 0;
        e_badop = 0; e_orphan = 0; e_timeout = 0;
        idle = 0;
    endtask

    function automatic int pick();
        for (int k = 1; k <= NREQ; k++) begin
            int i = (m_last + k) % NREQ;
            if (bus.req_vld[i]) return i;
        end
        return -1;
    endfunction

    task automatic advance(input int g);
        int   sz0;
        bit   nb, no, nt;
        tag_t t;
        logic [3:0] op;
        sz0 = q.size();
        nb = 0; no = 0; nt = 0;
        e_rsp_vld = 0;
        e_fu_vld  = 0;
        if (bus.fu_vldout) begin
            if (q.size() > 0) begin
                t = q.pop_front();
                e_rsp_vld = 1; e_rsp_id = t.id; e_rsp_dst = t.dst;
                e_rsp_res = bus.fu_result;
            end else begin
                no = 1;
            end
        end
        if (g >= 0) begin
            m_last = g;
            op = bus.req_oper[g*4 +: 4];
            if (op >= 1 && op <= 11) begin
                t.id = g; t.dst = int'(bus.req_dst[g*3 +: 3]);
                q.push_back(t);
                e_fu_vld = 1; e_op = 32'(op);
                e_s0 = bus.req_src0[g*32 +: 32];
                e_s1 = bus.req_src1[g*32 +: 32];
            end else begin
                nb = 1;
            end
        end
`ifdef FLT_SCHED_WATCHDOG_EN
        if (sz0 > 0 && !bus.fu_vldout) begin
            idle++;
            if (idle == TIMEOUT) begin
                q.delete();
                nt = 1;
                idle = 0;
            end
        end else begin
            idle = 0;
        end
`endif
        e_badop   = nb || (e_badop && !err_clr);
        e_orphan  = no || (e_orphan && !err_clr);
        e_timeout = nt || (e_timeout && !err_clr);
    endtask

    always @(negedge clk) begin
        int g;
        logic [NREQ-1:0] e_ack;
        if (rst) model_reset();
        g = (!rst && q.size() < DEPTH) ? pick() : -1;
        e_ack = '0;
        if (g >= 0) e_ack[g] = 1'b1;
        chk("req_ack", 32'(bus.req_ack), 32'(e_ack));
        chk("fu_vldin", 32'(bus.fu_vldin), 32'(e_fu_vld));
        if (e_fu_vld) begin
            chk("fu_oper", 32'(bus.fu_oper), e_op);
            chk("fu_src0", bus.fu_src0, e_s0);
            chk("fu_src1", bus.fu_src1, e_s1);
        end
        chk("rsp_vld", 32'(bus.rsp_vld), 32'(e_rsp_vld));
        if (e_rsp_vld) begin
            chk("rsp_id", 32'(bus.rsp_id), e_rsp_id);
            chk("rsp_dst", 32'(bus.rsp_dst), e_rsp_dst);
            chk("rsp_result", bus.rsp_result, e_rsp_res);
        end
        chk("outstanding", 32'(outstanding), 32'(q.size()));
        chk("err_badop", 32'(err_badop), 32'(e_badop));
        chk("err_orphan", 32'(err_orphan), 32'(e_orphan));
        chk("err_timeout", 32'(err_timeout), 32'(e_timeout));
        if (!rst) advance(g);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] d);
        bus.req_vld[i]          = 1'b1;
        bus.req_oper[i*4 +: 4]  = op;
        bus.req_src0[i*32 +: 32] = a;
        bus.req_src1[i*32 +: 32] = b;
        bus.req_dst[i*3 +: 3]   = d;
    endtask

    task automatic release_req(input int i);
        bus.req_vld[i] = 1'b0;
    endtask

    initial begin
        bus.req_vld = '0; bus.req_oper = '0; bus.req_src0 = '0;
        bus.req_src1 = '0; bus.req_dst = '0;
        bus.fu_vldout = 1'b0; bus.fu_result = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("lit_reset_outstanding", 32'(outstanding), 32'd0);
        chk("lit_reset_flags", 32'({err_badop, err_orphan, err_timeout}), 32'd0);

        // Single request from requester 0
        tick();
        drive(0, 4'd1, 32'h3f800000, 32'h40000000, 3'd5);
        @(negedge clk);
        chk("lit_t1_ack", 32'(bus.req_ack), 32'b01);
        tick();
        release_req(0);
        @(negedge clk);
        chk("lit_t1_fu_vldin", 32'(bus.fu_vldin), 32'd1);
        chk("lit_t1_fu_src0", bus.fu_src0, 32'h3f800000);
        chk("lit_t1_fu_src1", bus.fu_src1, 32'h40000000);
        tick();
        bus.fu_vldout = 1'b1; bus.fu_result = 32'h40400000;
        tick();
        bus.fu_vldout = 1'b0;
        @(negedge clk);
        chk("lit_t1_rsp_vld", 32'(bus.rsp_vld), 32'd1);
        chk("lit_t1_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("lit_t1_rsp_dst", 32'(bus.rsp_dst), 32'd5);
        chk("lit_t1_rsp_result", bus.rsp_result, 32'h40400000);

        // Contention from a fresh reset so requester 0 wins first
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        drive(0, 4'd3, 32'h11111111, 32'h22222222, 3'd1);
        drive(1, 4'd2, 32'h33333333, 32'h44444444, 3'd2);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("lit_cont_ack", 32'(bus.req_ack), (c % 2 == 0) ? 32'b01 : 32'b10);
            tick();
        end
        @(negedge clk);
        chk("lit_cont_stall_ack", 32'(bus.req_ack), 32'd0);
        chk("lit_cont_full", 32'(outstanding), 32'd4);
        tick();
        bus.fu_vldout = 1'b1; bus.fu_result = 32'hA0000001;
        @(negedge clk);
        chk("lit_pop_no_same_cycle_grant", 32'(bus.req_ack), 32'd0);
        tick();
        bus.fu_result = 32'hA0000002;
        @(negedge clk);
        chk("lit_credit_freed_ack", 32'(bus.req_ack), 32'b01);
        chk("lit_first_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("lit_first_rsp_dst", 32'(bus.rsp_dst), 32'd1);
        tick();
        bus.fu_vldout = 1'b0;
        @(negedge clk);
        chk("lit_push_pop_same", 32'(outstanding), 32'd3);
        tick();
        release_req(0); release_req(1);
        @(negedge clk);
        chk("lit_refill", 32'(outstanding), 32'd4);
        for (int r = 0; r < 4; r++) begin
            tick();
            bus.fu_vldout = 1'b1; bus.fu_result = 32'hB0000000 + 32'(r);
        end
        tick();
        bus.fu_vldout = 1'b0;
        @(negedge clk);
        chk("lit_drain_last_id", 32'(bus.rsp_id), 32'd1);
        tick();
        @(negedge clk);
        chk("lit_drained", 32'(outstanding), 32'd0);

        // Illegal opcodes from requester 1
        tick();
        drive(1, 4'd0, 32'h0, 32'h0, 3'd3);
        @(negedge clk);
        chk("lit_bad0_ack", 32'(bus.req_ack), 32'b10);
        tick();
        drive(1, 4'd13, 32'h0, 32'h0, 3'd4);
        @(negedge clk);
        chk("lit_bad13_ack", 32'(bus.req_ack), 32'b10);
        chk("lit_bad0_no_issue", 32'(bus.fu_vldin), 32'd0);
        tick();
        release_req(1);
        @(negedge clk);
        chk("lit_bad13_no_issue", 32'(bus.fu_vldin), 32'd0);
        chk("lit_badop_set", 32'(err_badop), 32'd1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        chk("lit_badop_clr", 32'(err_badop), 32'd0);

        // Reset with two operations in flight, then an orphan result
        tick();
        drive(0, 4'd8, 32'h40800000, 32'h40000000, 3'd6);
        tick();
        tick();
        release_req(0);
        @(negedge clk);
        chk("lit_two_inflight", 32'(outstanding), 32'd2);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("lit_reset_flush", 32'(outstanding), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        bus.fu_vldout = 1'b1; bus.fu_result = 32'hDEADBEEF;
        tick();
        bus.fu_vldout = 1'b0;
        @(negedge clk);
        chk("lit_orphan_set", 32'(err_orphan), 32'd1);
        chk("lit_orphan_no_rsp", 32'(bus.rsp_vld), 32'd0);

        // One operation that never returns
        tick();
        drive(0, 4'd9, 32'h41000000, 32'h0, 3'd7);
        tick();
        release_req(0);
        repeat (TIMEOUT + 8) tick();
        @(negedge clk);
`ifdef FLT_SCHED_WATCHDOG_EN
        chk("lit_wd_timeout", 32'(err_timeout), 32'd1);
        chk("lit_wd_flush", 32'(outstanding), 32'd0);
`else
        chk("lit_wd_timeout", 32'(err_timeout), 32'd0);
        chk("lit_wd_still_inflight", 32'(outstanding), 32'd1);
`endif
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL time_limit: simulation did not finish, got %0d of %0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
